// File: rtl/instruction_register_if.sv
// Memory read port of the instruction register: request out, word and valid strobe back.
interface instruction_register_if;
  logic        mem_req;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  modport master (output mem_req, input mem_valid, input mem_rdata);
  modport slave  (input mem_req, output mem_valid, output mem_rdata);
endinterface

// File: rtl/instruction_register.sv
// Instruction register: fetches a word over the memory port, holds it and
// decodes it into fixed instruction fields; a stalled fetch times out into fetch_err.
module instruction_register #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ir_write,
  input  logic                          flush,
  instruction_register_if.master        mem,
  output logic [31:0]                   instr,
  output logic [5:0]                    opcode,
  output logic [4:0]                    rs,
  output logic [4:0]                    rt,
  output logic [4:0]                    rd,
  output logic [4:0]                    shamt,
  output logic [5:0]                    funct,
  output logic [15:0]                   imm16,
  output logic [25:0]                   jaddr,
  output logic                          ir_valid,
  output logic                          busy,
  output logic                          fetch_err
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, HOLD} state_t;

  // Count value at the start of the last permitted WAIT_MEM cycle.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [31:0] instr_next;
  logic        valid_next;
  logic        err_next;
  logic [7:0]  wait_cnt, wait_next;
  logic        fetch_req;

  assign fetch_req   = (state == WAIT_MEM) || ir_write;
  assign mem.mem_req = fetch_req;
  assign busy        = fetch_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      instr     <= RESET_INSTR;
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_next;
      instr     <= instr_next;
      ir_valid  <= valid_next;
      fetch_err <= err_next;
      wait_cnt  <= wait_next;
    end
  end

  always_comb begin
    state_next = state;
    instr_next = instr;
    valid_next = ir_valid;
    err_next   = fetch_err;
    wait_next  = wait_cnt;

    if (flush) begin
      state_next = IDLE;
      valid_next = 1'b0;
    end else begin
      case (state)
        WAIT_MEM: begin
          if (mem.mem_valid) begin
            instr_next = mem.mem_rdata;
            valid_next = 1'b1;
            state_next = HOLD;
          end else begin
            wait_next = wait_cnt + 8'd1;
            if (wait_cnt == WAIT_LAST) begin
              err_next   = 1'b1;
              state_next = IDLE;
            end
          end
        end
        default: begin
          // IDLE and HOLD: a mem_valid without ir_write is dropped here.
          if (ir_write) begin
            err_next = 1'b0;
            if (mem.mem_valid) begin
              instr_next = mem.mem_rdata;
              valid_next = 1'b1;
              state_next = HOLD;
            end else begin
              valid_next = 1'b0;
              wait_next  = '0;
              state_next = WAIT_MEM;
            end
          end
        end
      endcase
    end
  end

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];
  assign jaddr  = instr[25:0];

endmodule

// File: tb/tb_instruction_register.sv
// Bench for instruction_register: directed vector table, hand sequences for
// timeout and mid-fetch reset, then random traffic against a reference model.
module tb_instruction_register;

  localparam logic [31:0] RESET_INSTR = 32'h0000_0000;
  localparam int unsigned TIMEOUT     = 15;

  logic        clk;
  logic        rst_n;
  logic        ir_write;
  logic        flush;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic        ir_valid, busy, fetch_err;

  instruction_register_if mem_bus ();

  instruction_register #(
    .RESET_INSTR(RESET_INSTR),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ir_write (ir_write),
    .flush    (flush),
    .mem      (mem_bus.master),
    .instr    (instr),
    .opcode   (opcode),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .funct    (funct),
    .imm16    (imm16),
    .jaddr    (jaddr),
    .ir_valid (ir_valid),
    .busy     (busy),
    .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: whether a fetch is outstanding and for how many cycles.
  bit          m_pending;
  int          m_waited;
  logic [31:0] m_instr;
  bit          m_valid;
  bit          m_err;

  typedef struct {
    bit          iw;
    bit          fl;
    bit          mv;
    logic [31:0] rdata;
    bit          req;
    logic [31:0] instr;
    bit          valid;
    bit          err;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pending = 1'b0;
    m_waited  = 0;
    m_instr   = RESET_INSTR;
    m_valid   = 1'b0;
    m_err     = 1'b0;
  endtask

  task automatic model_edge(input bit iw, input bit fl, input bit mv, input logic [31:0] rdata);
    if (fl) begin
      m_pending = 1'b0;
      m_valid   = 1'b0;
    end else if (m_pending) begin
      if (mv) begin
        m_instr   = rdata;
        m_valid   = 1'b1;
        m_pending = 1'b0;
      end else begin
        m_waited = m_waited + 1;
        if (m_waited == int'(TIMEOUT)) begin
          m_err     = 1'b1;
          m_pending = 1'b0;
        end
      end
    end else if (iw) begin
      m_err = 1'b0;
      if (mv) begin
        m_instr = rdata;
        m_valid = 1'b1;
      end else begin
        m_pending = 1'b1;
        m_waited  = 0;
        m_valid   = 1'b0;
      end
    end
  endtask

  task automatic check_regs();
    logic [31:0] e;
    e = m_instr;
    chk("instr",     instr,     e);
    chk("ir_valid",  ir_valid,  m_valid);
    chk("fetch_err", fetch_err, m_err);
    chk("opcode",    opcode,    e[31:26]);
    chk("rs",        rs,        e[25:21]);
    chk("rt",        rt,        e[20:16]);
    chk("rd",        rd,        e[15:11]);
    chk("shamt",     shamt,     e[10:6]);
    chk("funct",     funct,     e[5:0]);
    chk("imm16",     imm16,     e[15:0]);
    chk("jaddr",     jaddr,     e[25:0]);
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic step(input bit iw, input bit fl, input bit mv, input logic [31:0] rdata,
                      output logic req_seen);
    ir_write          = iw;
    flush             = fl;
    mem_bus.mem_valid = mv;
    mem_bus.mem_rdata = rdata;
    #1;
    req_seen = mem_bus.mem_req;
    chk("mem_req", mem_bus.mem_req, m_pending || iw);
    chk("busy",    busy,            m_pending || iw);
    @(posedge clk);
    model_edge(iw, fl, mv, rdata);
    #1;
    check_regs();
  endtask

  initial begin
    logic r;
    int   mv_pct;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h3C01_FFFF, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h3C01_FFFF, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h3C01_FFFF, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h3C01_FFFF, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h2022_7FFF, 1'b1, 32'h2022_7FFF, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h2022_7FFF, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h2022_7FFF, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b1, 32'h2022_7FFF, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h2222_2222, 1'b0, 32'h2022_7FFF, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h3333_3333, 1'b1, 32'h2022_7FFF, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h2022_7FFF, 1'b0, 1'b0};

    rst_n             = 1'b0;
    ir_write          = 1'b0;
    flush             = 1'b0;
    mem_bus.mem_valid = 1'b0;
    mem_bus.mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    chk("rst_instr",    instr,           32'h0000_0000);
    chk("rst_ir_valid", ir_valid,        1'b0);
    chk("rst_mem_req",  mem_bus.mem_req, 1'b0);
    chk("rst_busy",     busy,            1'b0);
    chk("rst_err",      fetch_err,       1'b0);

    // Zero-wait fetch.
    step(1'b1, 1'b0, 1'b1, 32'h3C01_FFFF, r);
    chk("zw_req",    r,        1'b1);
    chk("zw_instr",  instr,    32'h3C01_FFFF);
    chk("zw_opcode", opcode,   6'h0F);
    chk("zw_rt",     rt,       5'd1);
    chk("zw_imm16",  imm16,    16'hFFFF);
    chk("zw_valid",  ir_valid, 1'b1);

    // Three-cycle wait, ignored ir_write, discarded stray mem_valid, flushes.
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].iw, tbl[i].fl, tbl[i].mv, tbl[i].rdata, r);
      chk($sformatf("tbl%0d_req", i),   r,         tbl[i].req);
      chk($sformatf("tbl%0d_instr", i), instr,     tbl[i].instr);
      chk($sformatf("tbl%0d_valid", i), ir_valid,  tbl[i].valid);
      chk($sformatf("tbl%0d_err", i),   fetch_err, tbl[i].err);
    end
    chk("wait_imm16", imm16, 16'h7FFF);

    // Timeout: error raised exactly after TIMEOUT waiting cycles.
    step(1'b1, 1'b0, 1'b0, 32'h0, r);
    for (int i = 1; i <= int'(TIMEOUT); i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, r);
      chk($sformatf("to_busy%0d", i), r,         1'b1);
      chk($sformatf("to_err%0d", i),  fetch_err, (i == int'(TIMEOUT)) ? 1'b1 : 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 32'h4444_4444, r);
    chk("to_idle_req", r,         1'b0);
    chk("to_instr",    instr,     32'h2022_7FFF);
    chk("to_valid",    ir_valid,  1'b0);
    chk("to_sticky",   fetch_err, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h5555_5555, r);
    chk("to_clear",    fetch_err, 1'b0);
    chk("to_refetch",  instr,     32'h5555_5555);

    // Reset pulsed in the middle of a wait, then a late mem_valid.
    step(1'b1, 1'b0, 1'b0, 32'h0, r);
    step(1'b0, 1'b0, 1'b0, 32'h0, r);
    rst_n = 1'b0;
    #1;
    chk("ar_instr", instr,     RESET_INSTR);
    chk("ar_valid", ir_valid,  1'b0);
    chk("ar_err",   fetch_err, 1'b0);
    chk("ar_busy",  busy,      1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b1, 32'h6666_6666, r);
    chk("ar_late_req",   r,        1'b0);
    chk("ar_late_instr", instr,    RESET_INSTR);
    chk("ar_late_valid", ir_valid, 1'b0);

    // Random traffic; some segments starve mem_valid to provoke timeouts.
    for (int seg = 0; seg < 6; seg++) begin
      case (seg)
        0: mv_pct = 40;
        1: mv_pct = 5;
        2: mv_pct = 0;
        3: mv_pct = 60;
        4: mv_pct = 20;
        default: mv_pct = 0;
      endcase
      for (int c = 0; c < 60; c++) begin
        step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4,
             $urandom_range(0, 99) < mv_pct, $urandom, r);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_register.md
INSTRUCTION_REGISTER -- requirements
Module: instruction_register

Interface
REQ-001 SHALL have parameter RESET_INSTR, default 32'h0000_0000, giving the instruction held after reset (NOP).
REQ-002 SHALL have parameter TIMEOUT, default 15, giving the maximum WAIT_MEM cycles before fetch_err is raised (range 1-255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ir_write  input  1  fetch request pulse from the control FSM.
REQ-006 SHALL have port flush  input  1  abandons any pending fetch and invalidates the held instruction.
REQ-007 SHALL have port mem_valid  input  1  mem_rdata is valid this cycle.
REQ-008 SHALL have port mem_rdata  input  32  instruction word from memory.
REQ-009 SHALL have port mem_req  output  1  memory read request, high while a fetch is outstanding.
REQ-010 SHALL have port instr  output  32  latched instruction word.
REQ-011 SHALL have ports opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm16[15:0] and jaddr[25:0] as outputs, each a pure bit slice of instr.
REQ-012 SHALL have port ir_valid  output  1  instr holds a fetched, unflushed instruction.
REQ-013 SHALL have port busy  output  1  a fetch is outstanding; the control FSM stalls on it.
REQ-014 SHALL have port fetch_err  output  1  sticky timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_MEM and HOLD.
REQ-016 In IDLE or HOLD, with ir_write=1 and mem_valid=0, SHALL go to WAIT_MEM next cycle.
REQ-017 In IDLE or HOLD, with ir_write=1 and mem_valid=1 in the same cycle, SHALL capture mem_rdata into instr at that edge and go to HOLD (zero-wait fetch).
REQ-018 In WAIT_MEM with mem_valid=1, SHALL capture mem_rdata into instr and go to HOLD.
REQ-019 SHALL ignore ir_write while in WAIT_MEM.
REQ-020 SHALL assert ir_valid in the cycle after a capture edge and hold it until the next ir_write acceptance or flush.
REQ-021 SHALL keep instr unchanged in every cycle without a capture.
REQ-022 SHALL drive mem_req and busy combinationally: 1 in WAIT_MEM, and 1 in IDLE or HOLD while ir_write=1; 0 otherwise.
REQ-023 SHALL clear ir_valid on the edge where ir_write is accepted.
REQ-024 SHALL drive the field slices combinationally from instr; imm16 feeds the immediate extender directly.
REQ-025 SHALL run a wait counter, 8 bits wide, that clears on entry to WAIT_MEM and increments each WAIT_MEM cycle without mem_valid.
REQ-026 When the wait counter reaches TIMEOUT, SHALL set fetch_err, return to IDLE and leave instr unchanged.
REQ-027 SHALL keep fetch_err set until reset or until the next accepted ir_write.
REQ-028 flush=1 SHALL force state IDLE and ir_valid=0 next edge, taking priority over mem_valid and ir_write in the same cycle.
REQ-029 SHALL leave instr unchanged on flush.
REQ-030 SHALL discard a mem_valid that arrives in IDLE or HOLD with ir_write=0.

Reset
REQ-031 While rst_n=0, SHALL asynchronously force instr=RESET_INSTR, state IDLE, ir_valid=0, fetch_err=0 and wait counter=0; mem_req=0 and busy=0 then follow from REQ-022.
REQ-032 SHALL abort a fetch in progress on reset assertion; a late mem_valid after release SHALL be discarded.

Verification
REQ-033 Bench SHALL cover: reset release -> instr=32'h0, ir_valid=0, mem_req=0.
REQ-034 Bench SHALL cover: ir_write plus mem_valid in the same cycle with mem_rdata=32'h3C01_FFFF -> next cycle instr=32'h3C01_FFFF, opcode=6'h0F, rt=5'd1, imm16=16'hFFFF, ir_valid=1.
REQ-035 Bench SHALL cover: ir_write, then mem_valid 3 cycles later with 32'h2022_7FFF -> busy high for 3 cycles, then imm16=16'h7FFF, ir_valid=1.
REQ-036 Bench SHALL cover: ir_write with no mem_valid, TIMEOUT=15 -> fetch_err=1 after 15 WAIT_MEM cycles, state IDLE, instr unchanged.
REQ-037 Bench SHALL cover: flush coincident with mem_valid in WAIT_MEM -> ir_valid=0, instr unchanged, state IDLE.
REQ-038 Bench SHALL cover: rst_n pulsed low mid-WAIT_MEM, then mem_valid after release -> instr=RESET_INSTR, ir_valid=0.
